// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, FSM states and sample field ordering for the PWM decode path
package pwm_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_MEAS = 1'b1} state_t;
  typedef struct packed {
    logic                 stuck;
    logic [CNT_W_DEF-1:0] high;
    logic [CNT_W_DEF-1:0] period;
  } sample_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: N-stage synchroniser with registered rising-edge detect
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic              level_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync    <= '0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[STAGES-2:0], pin};
      level_d <= sync[STAGES-1];
    end
  assign level = sync[STAGES-1];
  assign rise  = level & ~level_d;
endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures PWM high time and period between rises, reports stuck pins
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  input  logic             s_ready,
  input  logic             clr_ovr,
  output logic             s_valid,
  output logic [CNT_W-1:0] s_high,
  output logic [CNT_W-1:0] s_period,
  output logic             s_stuck,
  output logic             overrun
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic             pwm_s, rise, emit, stuck, emit_q, stuck_q, load, drop;
  logic [CNT_W-1:0] per_cnt, hi_cnt, per_nx, hi_nx, hi_q, per_q;
  state_t           state, state_nx;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (pwm_in),
    .level(pwm_s),
    .rise (rise)
  );

  // timeout is checked before rise in MEAS so a period of MAX or more is always stuck
  always_comb begin
    state_nx = state;
    per_nx   = per_cnt + CNT_W'(1);
    hi_nx    = '0;
    emit     = 1'b0;
    stuck    = 1'b0;
    if (!en) begin
      state_nx = ST_IDLE;
      per_nx   = '0;
    end else if (state == ST_IDLE) begin
      if (rise) begin
        state_nx = ST_MEAS;
        per_nx   = CNT_W'(1);
        hi_nx    = CNT_W'(1);
      end else if (per_cnt == MAX) begin
        emit   = 1'b1;
        stuck  = 1'b1;
        per_nx = '0;
      end
    end else if (per_cnt == MAX) begin
      emit     = 1'b1;
      stuck    = 1'b1;
      state_nx = ST_IDLE;
      per_nx   = '0;
    end else if (rise) begin
      emit   = 1'b1;
      per_nx = CNT_W'(1);
      hi_nx  = CNT_W'(1);
    end else begin
      hi_nx = hi_cnt + CNT_W'(pwm_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
      emit_q  <= 1'b0;
      stuck_q <= 1'b0;
      hi_q    <= '0;
      per_q   <= '0;
    end else begin
      state   <= state_nx;
      per_cnt <= per_nx;
      hi_cnt  <= hi_nx;
      emit_q  <= emit;
      stuck_q <= stuck;
      hi_q    <= stuck ? (pwm_s ? MAX : '0) : hi_cnt;
      per_q   <= stuck ? MAX : per_cnt;
    end

  assign load = emit_q & (~s_valid | s_ready);
  assign drop = emit_q & s_valid & ~s_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_valid  <= 1'b0;
      s_high   <= '0;
      s_period <= '0;
      s_stuck  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load) begin
        s_valid  <= 1'b1;
        s_high   <= hi_q;
        s_period <= per_q;
        s_stuck  <= stuck_q;
      end else if (s_ready) begin
        s_valid <= 1'b0;
      end
      overrun <= drop | (overrun & ~clr_ovr);
    end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: randomized PWM stimulus checked against a per-period sample model
module tb_pwm_duty_decoder;
  logic       clk = 0, rst_n = 0, en = 1, pwm_in = 0, s_ready = 1, clr_ovr = 0;
  logic       s_valid, s_stuck, overrun;
  logic [7:0] s_high, s_period;
  int errs = 0, checks = 0, cyc = 0, clr_cyc = -1, en_off = 1 << 30;
  typedef struct {logic [16:0] s; int c;} smp_t;
  smp_t obs[$], expq[$];
  bit have_prev = 0, model_on = 1;
  int ph, pp;

  always #5 clk = ~clk;

  pwm_duty_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .pwm_in  (pwm_in),
    .s_ready (s_ready),
    .clr_ovr (clr_ovr),
    .s_valid (s_valid),
    .s_high  (s_high),
    .s_period(s_period),
    .s_stuck (s_stuck),
    .overrun (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step(input logic pin);
    pwm_in  = pin;
    clr_ovr = (cyc == clr_cyc);
    en      = (cyc < en_off);
    if (s_valid && s_ready) obs.push_back('{{s_stuck, s_high, s_period}, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // each call starts with a pin rise; the model predicts what that rise reports
  task automatic period(input int h, input int p);
    if (model_on) begin
      if (have_prev) expq.push_back('{{1'b0, 8'(ph), 8'(pp)}, cyc + 4});
      if (p >= 255) begin
        expq.push_back('{{1'b1, 8'd0, 8'd255}, -1});
        have_prev = 0;
      end else begin
        have_prev = 1;
        ph = h;
        pp = p;
      end
    end
    for (int i = 0; i < p; i++) step(i < h);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, obs.size(), expq.size());
    for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(obs[i].s), 32'(expq[i].s));
      if (expq[i].c >= 0) chk($sformatf("%s_lat%0d", tag, i), obs[i].c, expq[i].c);
    end
    obs.delete();
    expq.delete();
  endtask

  task automatic do_reset(input logic pin);
    rst_n = 0;
    repeat (3) step(pin);
    rst_n = 1;
    have_prev = 0;
    obs.delete();
    expq.delete();
  endtask

  task automatic stuck_run(input string tag, input logic pin);
    do_reset(pin);
    repeat (820) step(pin);
    chk({tag, "_n"}, 32'(obs.size() >= 3), 1);
    for (int i = 0; i < 3 && i < obs.size(); i++)
      chk($sformatf("%s_data%0d", tag, i), 32'(obs[i].s), {15'd0, 1'b1, pin ? 8'd255 : 8'd0, 8'd255});
    if (obs.size() >= 3) chk({tag, "_gap"}, 32'((obs[2].c - obs[1].c) inside {[255:256]}), 1);
    obs.delete();
  endtask

  initial begin
    int p;
    rst_n = 0;
    repeat (3) step(0);
    chk("reset_out", {s_valid, s_stuck, overrun, s_high, s_period}, 0);
    rst_n = 1;

    period(25, 100); period(25, 100); period(25, 100);
    period(1, 10); period(1, 10); period(9, 10); period(9, 10);
    repeat (14) begin
      p = $urandom_range(200, 2);
      period($urandom_range(p - 1, 1), p);
    end
    repeat (8) step(0);
    compare("meas");

    stuck_run("stuck_hi", 1);
    stuck_run("stuck_lo", 0);

    do_reset(0);
    period(50, 300); period(30, 100); period(30, 100);
    repeat (8) step(0);
    compare("timeout");

    do_reset(0);
    model_on = 0;
    s_ready = 0;
    repeat (5) period(20, 50);
    chk("ovr_valid", s_valid, 1);
    chk("ovr_hold", {s_stuck, s_high, s_period}, {1'b0, 8'd20, 8'd50});
    chk("ovr_set", overrun, 1);
    s_ready = 1;
    period(20, 50);
    chk("ovr_drain_n", obs.size(), 2);
    foreach (obs[i]) chk($sformatf("ovr_drain%0d", i), 32'(obs[i].s), {1'b0, 8'd20, 8'd50});
    obs.delete();
    chk("ovr_sticky", overrun, 1);
    s_ready = 0;
    clr_cyc = cyc + 10;
    period(20, 50);
    chk("ovr_clr", overrun, 0);
    chk("ovr_valid2", s_valid, 1);
    clr_cyc = cyc + 3;
    period(20, 50);
    chk("ovr_set_wins", overrun, 1);
    clr_cyc = -1;
    s_ready = 1;
    repeat (3) step(0);
    obs.delete();

    do_reset(0);
    s_ready = 0;
    period(20, 50); period(20, 50); period(20, 50);
    step(0);
    chk("pre_rst_state", {s_valid, overrun}, 2'b11);
    #2 rst_n = 0;
    #1 chk("async_rst", {s_valid, s_stuck, overrun, s_high, s_period}, 0);
    repeat (2) step(0);
    rst_n = 1;
    have_prev = 0;
    model_on = 1;
    s_ready = 1;
    obs.delete();
    period(20, 60); period(20, 60); period(20, 60);
    repeat (8) step(0);
    compare("rst_restart");

    do_reset(0);
    model_on = 0;
    s_ready = 0;
    period(20, 60);
    en_off = cyc + 30;
    repeat (4) period(20, 60);
    chk("en_overrun", overrun, 0);
    chk("en_valid", s_valid, 1);
    chk("en_held", {s_stuck, s_high, s_period}, {1'b0, 8'd20, 8'd60});
    s_ready = 1;
    repeat (3) step(0);
    chk("en_drain_n", obs.size(), 1);
    if (obs.size() > 0) chk("en_drain_data", 32'(obs[0].s), {1'b0, 8'd20, 8'd60});
    chk("en_drain_done", s_valid, 0);
    en_off = 1 << 30;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
